// File: rtl/tdc_measure_ctrl.sv
// Measurement sequencer for the inverter delay-line timing sensor: launches the line,
// waits for it to settle, captures the thermometer taps and averages 2^n tap counts.
module tdc_measure_ctrl #(
  parameter int N_DELAY    = 16,
  parameter int SETTLE_CYC = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [1:0]                         cfg_avg_log2,
  input  logic [N_DELAY-1:0]                 taps,
  output logic                               launch,
  output logic                               busy,
  output logic [$clog2(N_DELAY+1)-1:0]       result,
  output logic                               result_valid,
  input  logic                               result_ready,
  output logic                               bubble_err
);

  localparam int CNT_W = $clog2(N_DELAY + 1);
  localparam int ACC_W = CNT_W + 3;
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_SETTLE  = 3'd2,
    S_CAPTURE = 3'd3,
    S_ACCUM   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Number of consecutive ones starting at tap 0.
  function automatic logic [CNT_W-1:0] therm_count(input logic [N_DELAY-1:0] v);
    logic [CNT_W-1:0] c;
    logic             run;
    c   = '0;
    run = 1'b1;
    for (int i = 0; i < N_DELAY; i++) begin
      if (run && v[i]) begin
        c = c + CNT_W'(1);
      end else begin
        run = 1'b0;
      end
    end
    return c;
  endfunction

  // A one sitting above the first zero means the snapshot is not a clean thermometer code.
  function automatic logic therm_bubble(input logic [N_DELAY-1:0] v);
    logic seen_zero;
    logic bub;
    seen_zero = 1'b0;
    bub       = 1'b0;
    for (int i = 0; i < N_DELAY; i++) begin
      if (!v[i]) begin
        seen_zero = 1'b1;
      end else if (seen_zero) begin
        bub = 1'b1;
      end else begin
        bub = bub;
      end
    end
    return bub;
  endfunction

  state_t               state_q, state_d;
  logic [SET_W-1:0]     settle_q, settle_d;
  logic [2:0]           sample_q, sample_d;
  logic [1:0]           n_q, n_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [N_DELAY-1:0]   snap_q, snap_d;
  logic [CNT_W-1:0]     result_q, result_d;
  logic                 valid_q, valid_d;
  logic                 bubble_q, bubble_d;
  logic                 launch_q, launch_d;
  logic                 busy_q, busy_d;

  logic [CNT_W-1:0]     count_s;
  logic                 bubble_s;
  logic [ACC_W-1:0]     acc_sum_s;
  logic                 last_s;

  // Next-state and datapath update for the measurement sequence.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    sample_d  = sample_q;
    n_d       = n_q;
    acc_d     = acc_q;
    snap_d    = snap_q;
    result_d  = result_q;
    valid_d   = valid_q;
    bubble_d  = bubble_q;
    count_s   = therm_count(snap_q);
    bubble_s  = therm_bubble(snap_q);
    acc_sum_s = acc_q + ACC_W'(count_s);
    last_s    = ({1'b0, sample_q} == ((4'd1 << n_q) - 4'd1));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LAUNCH;
          n_d      = cfg_avg_log2;
          acc_d    = '0;
          sample_d = 3'd0;
          bubble_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LAUNCH: begin
        settle_d = '0;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
          state_d = S_CAPTURE;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      S_CAPTURE: begin
        snap_d  = taps;
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        acc_d = acc_sum_s;
        if (bubble_s) begin
          bubble_d = 1'b1;
        end else begin
          bubble_d = bubble_q;
        end
        // Result is taken from the post-add sum so the last sample counts.
        if (last_s) begin
          result_d = CNT_W'(acc_sum_s >> n_q);
          valid_d  = 1'b1;
          state_d  = S_DONE;
        end else begin
          sample_d = sample_q + 3'd1;
          state_d  = S_LAUNCH;
        end
      end
      S_DONE: begin
        if (result_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase

    launch_d = (state_d == S_LAUNCH);
    busy_d   = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      sample_q <= 3'd0;
      n_q      <= 2'd0;
      acc_q    <= '0;
      snap_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      bubble_q <= 1'b0;
      launch_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      sample_q <= sample_d;
      n_q      <= n_d;
      acc_q    <= acc_d;
      snap_q   <= snap_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      bubble_q <= bubble_d;
      launch_q <= launch_d;
      busy_q   <= busy_d;
    end
  end

  assign launch       = launch_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign bubble_err   = bubble_q;

endmodule
